rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl -- board reset sequencer.
//
// Synchronises the two board reset buttons and the MMCM lock, debounces the
// buttons, holds every reset output low while any reset request is present,
// then releases NUM_STAGES active-low resets one after another (bit 0 first)
// with STAGE_DELAY cycles between releases. Reports the cause of the last
// reset and a saturating count of non-POR reset events.
//
// Ports:
//   clk            sequencer clock (free-running, always-on)
//   rst_n          asynchronous active-low reset (power-on reset)
//   btn_fpga_rst_n async board button, low = pressed
//   btn_mcu_rst    async board button, high = pressed
//   pll_locked     async MMCM lock indication
//   rst_out_n      sequenced active-low resets, bit 0 released first
//   seq_done       high once every stage is released
//   rst_cause      last cause: 0 POR, 1 fpga button, 2 mcu button, 3 lock loss
//   rst_event_cnt  saturating count of non-POR reset events
module rst_seq_ctrl #(
  parameter int NUM_STAGES      = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int STAGE_DELAY     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_fpga_rst_n,
  input  logic                  btn_mcu_rst,
  input  logic                  pll_locked,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  seq_done,
  output logic [1:0]            rst_cause,
  output logic [7:0]            rst_event_cnt
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Simultaneous causes resolve fpga > mcu > lock.
  function automatic logic [1:0] cause_of(input logic fpga, input logic mcu);
    if (fpga) return 2'd1;
    if (mcu)  return 2'd2;
    return 2'd3;
  endfunction

  // ---- synchroniser stage ----
  // Flops reset to the "asserted" level so the block comes out of POR
  // still requesting reset until the real inputs have propagated.
  logic [SYNC_STAGES-1:0] fpga_sync, mcu_sync, lock_sync;
  logic                   fpga_s, mcu_s, lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpga_sync <= '0;
      mcu_sync  <= '1;
      lock_sync <= '0;
    end else begin
      fpga_sync <= {fpga_sync[SYNC_STAGES-2:0], btn_fpga_rst_n};
      mcu_sync  <= {mcu_sync[SYNC_STAGES-2:0], btn_mcu_rst};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign fpga_s = fpga_sync[SYNC_STAGES-1];
  assign mcu_s  = mcu_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];

  // ---- debounce stage ----
  // The counter only runs while the synced level disagrees with the
  // debounced level; any agreeing cycle restarts it.
  logic            fpga_db, mcu_db;
  logic [DB_W-1:0] fpga_db_cnt, mcu_db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpga_db     <= 1'b0;
      fpga_db_cnt <= '0;
    end else if (fpga_s == fpga_db) begin
      fpga_db_cnt <= '0;
    end else if (fpga_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      fpga_db     <= fpga_s;
      fpga_db_cnt <= '0;
    end else begin
      fpga_db_cnt <= fpga_db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcu_db     <= 1'b1;
      mcu_db_cnt <= '0;
    end else if (mcu_s == mcu_db) begin
      mcu_db_cnt <= '0;
    end else if (mcu_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      mcu_db     <= mcu_s;
      mcu_db_cnt <= '0;
    end else begin
      mcu_db_cnt <= mcu_db_cnt + DB_W'(1);
    end
  end

  logic fpga_pressed, mcu_pressed, req;

  assign fpga_pressed = ~fpga_db;
  assign mcu_pressed  = mcu_db;
  assign req          = fpga_pressed | mcu_pressed | ~lock_s;

  // ---- sequencer stage ----
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_STAGES-1:0] rst_nxt;
  logic                  done_nxt;
  logic [1:0]            cause_nxt;
  logic [7:0]            evcnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HOLD;
      cnt           <= '0;
      rst_out_n     <= '0;
      seq_done      <= 1'b0;
      rst_cause     <= 2'd0;
      rst_event_cnt <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rst_out_n     <= rst_nxt;
      seq_done      <= done_nxt;
      rst_cause     <= cause_nxt;
      rst_event_cnt <= evcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rst_nxt   = rst_out_n;
    done_nxt  = seq_done;
    cause_nxt = rst_cause;
    evcnt_nxt = rst_event_cnt;
    case (state)
      HOLD: begin
        rst_nxt  = '0;
        done_nxt = 1'b0;
        if (req) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(HOLD_CYCLES)) begin
          // HOLD_CYCLES full request-free cycles have elapsed.
          rst_nxt = NUM_STAGES'(1);
          cnt_nxt = '0;
          if (NUM_STAGES == 1) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RELEASE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RELEASE, RUN: begin
        if (req) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          rst_nxt   = '0;
          done_nxt  = 1'b0;
          cause_nxt = cause_of(fpga_pressed, mcu_pressed);
          evcnt_nxt = sat_inc(rst_event_cnt);
        end else if (state == RELEASE) begin
          if (cnt == CNT_W'(STAGE_DELAY - 1)) begin
            // Released bits form a contiguous run from bit 0, so shifting
            // in a one releases exactly the next stage.
            rst_nxt = (rst_out_n << 1) | NUM_STAGES'(1);
            cnt_nxt = '0;
            if (&rst_nxt) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
        rst_nxt   = '0;
        done_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
module tb_rst_seq_ctrl;
  localparam int NUM  = 3;
  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int HOLD = 64;
  localparam int SD   = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           btn_fpga_rst_n = 1'b1;
  logic           btn_mcu_rst = 1'b0;
  logic           pll_locked = 1'b1;
  logic [NUM-1:0] rst_out_n;
  logic           seq_done;
  logic [1:0]     rst_cause;
  logic [7:0]     rst_event_cnt;

  always #5 clk = ~clk;

  rst_seq_ctrl #(
    .NUM_STAGES(NUM), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD), .STAGE_DELAY(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_fpga_rst_n(btn_fpga_rst_n),
    .btn_mcu_rst(btn_mcu_rst), .pll_locked(pll_locked),
    .rst_out_n(rst_out_n), .seq_done(seq_done), .rst_cause(rst_cause),
    .rst_event_cnt(rst_event_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen through a SYNC-deep delay, buttons accepted
  // after DEB identical synced samples, and the release schedule expressed as
  // "how many stages are out" from the time stage 0 went.
  bit qf[$], qm[$], ql[$];
  bit dbf_p, dbm_p;
  bit lastf, lastm;
  int runf, runm;
  int released, quiet, t_rel, edge_n, m_cause, m_cnt;

  task automatic model_reset();
    qf.delete(); qm.delete(); ql.delete();
    dbf_p = 1'b1; dbm_p = 1'b1;
    lastf = 1'b0; lastm = 1'b1;
    runf = 0; runm = 0;
    released = 0; quiet = 0; t_rel = 0; edge_n = 0;
    m_cause = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit sf, sm, sl, req;
    edge_n++;
    sf = (qf.size() >= SYNC) ? qf[qf.size()-SYNC] : 1'b0;
    sm = (qm.size() >= SYNC) ? qm[qm.size()-SYNC] : 1'b1;
    sl = (ql.size() >= SYNC) ? ql[ql.size()-SYNC] : 1'b0;
    qf.push_back(btn_fpga_rst_n); if (qf.size() > SYNC) void'(qf.pop_front());
    qm.push_back(btn_mcu_rst);    if (qm.size() > SYNC) void'(qm.pop_front());
    ql.push_back(pll_locked);     if (ql.size() > SYNC) void'(ql.pop_front());
    req = dbf_p | dbm_p | !sl;
    if (released > 0 && req) begin
      released = 0;
      quiet    = 0;
      m_cause  = dbf_p ? 1 : (dbm_p ? 2 : 3);
      if (m_cnt < 255) m_cnt++;
    end else if (released == 0) begin
      quiet = req ? 0 : quiet + 1;
      if (quiet == HOLD + 1) begin
        released = 1;
        t_rel    = edge_n;
        quiet    = 0;
      end
    end else begin
      released = 1 + (edge_n - t_rel) / SD;
      if (released > NUM) released = NUM;
    end
    if (sf == lastf) runf++; else runf = 1;
    lastf = sf;
    if (((!sf) != dbf_p) && runf >= DEB) dbf_p = !sf;
    if (sm == lastm) runm++; else runm = 1;
    lastm = sm;
    if ((sm != dbm_p) && runm >= DEB) dbm_p = sm;
  endtask

  task automatic tick();
    logic [NUM-1:0] exp_rst;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    exp_rst = NUM'((1 << released) - 1);
    check("rst_out_n", 32'(rst_out_n), 32'(exp_rst));
    check("seq_done", 32'(seq_done), 32'(released == NUM));
    check("rst_cause", 32'(rst_cause), 32'(m_cause));
    check("rst_event_cnt", 32'(rst_event_cnt), 32'(m_cnt));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return rst_out_n == '0;
      1:       return rst_out_n[0];
      2:       return seq_done;
      default: return rst_out_n[0] && !seq_done;
    endcase
  endfunction

  task automatic wait_cond(input string tag, input int which, input int max_cyc, output int cyc);
    cyc = 0;
    while (!cond(which) && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    check({tag, "_reached"}, 32'(cond(which)), 32'd1);
  endtask

  // Called just after a falling edge, so the pulse sits between rising edges.
  task automatic async_pulse(input bit do_check);
    #1 rst_n = 1'b0;
    #1;
    if (do_check) begin
      check("arst_rst_out_n", 32'(rst_out_n), 32'd0);
      check("arst_seq_done", 32'(seq_done), 32'd0);
      check("arst_cause", 32'(rst_cause), 32'd0);
      check("arst_cnt", 32'(rst_event_cnt), 32'd0);
    end
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int c, e0, e1, e2, ed, len;
    model_reset();
    run(3);
    check("por_rst_out_n", 32'(rst_out_n), 32'd0);
    check("por_cause", 32'(rst_cause), 32'd0);

    // Power-on release schedule with idle inputs.
    rst_n = 1'b1;
    e0 = 0; e1 = 0; e2 = 0; ed = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (rst_out_n[0] && e0 == 0) e0 = k;
      if (rst_out_n[1] && e1 == 0) e1 = k;
      if (rst_out_n[2] && e2 == 0) e2 = k;
      if (seq_done && ed == 0) ed = k;
    end
    check("por_rel0_edge", e0, SYNC + DEB + HOLD + 1);
    check("por_rel1_edge", e1, SYNC + DEB + HOLD + 1 + SD);
    check("por_rel2_edge", e2, SYNC + DEB + HOLD + 1 + 2 * SD);
    check("por_done_edge", ed, SYNC + DEB + HOLD + 1 + 2 * SD);
    check("por_cnt", 32'(rst_event_cnt), 32'd0);

    // FPGA button held for 40 cycles.
    btn_fpga_rst_n = 1'b0;
    wait_cond("fpga_low", 0, 60, c);
    check("fpga_latency", c, SYNC + DEB + 1);
    check("fpga_cause", 32'(rst_cause), 32'd1);
    check("fpga_cnt", 32'(rst_event_cnt), 32'd1);
    run(40 - c);
    btn_fpga_rst_n = 1'b1;
    wait_cond("fpga_rel0", 1, 200, c);
    check("fpga_rerelease", c, SYNC + DEB + HOLD + 1);
    wait_cond("fpga_done", 2, 100, c);

    // Short MCU glitch is filtered.
    btn_mcu_rst = 1'b1;
    run(10);
    btn_mcu_rst = 1'b0;
    run(40);
    check("glitch_done", 32'(seq_done), 32'd1);
    check("glitch_out", 32'(rst_out_n), 32'd7);
    check("glitch_cnt", 32'(rst_event_cnt), 32'd1);

    // Lock loss in RUN, then again mid-release.
    pll_locked = 1'b0;
    run(5);
    pll_locked = 1'b1;
    wait_cond("lock_rel0", 3, 200, c);
    pll_locked = 1'b0;
    wait_cond("lock_low", 0, 20, c);
    check("lock_latency", c, SYNC + 1);
    check("lock_cause", 32'(rst_cause), 32'd3);
    check("lock_cnt", 32'(rst_event_cnt), 32'd3);
    pll_locked = 1'b1;
    wait_cond("lock_done", 2, 300, c);

    // Both buttons together: fpga wins.
    btn_fpga_rst_n = 1'b0;
    btn_mcu_rst    = 1'b1;
    run(30);
    check("both_cause", 32'(rst_cause), 32'd1);
    check("both_cnt", 32'(rst_event_cnt), 32'd4);
    btn_fpga_rst_n = 1'b1;
    btn_mcu_rst    = 1'b0;
    wait_cond("both_done", 2, 400, c);

    // Async reset in the middle of a release.
    pll_locked = 1'b0;
    run(4);
    pll_locked = 1'b1;
    wait_cond("mid_rel0", 3, 200, c);
    async_pulse(1'b1);
    wait_cond("por2_done", 2, 200, c);
    check("por2_done_edges", c, SYNC + DEB + HOLD + 1 + (NUM - 1) * SD);

    // Saturate the event counter with repeated lock drops.
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      run(4);
      pll_locked = 1'b1;
      wait_cond("sat_rel0", 1, 200, c);
      if (i == 254) check("sat_cnt_255", 32'(rst_event_cnt), 32'd255);
    end
    check("sat_cnt_stays", 32'(rst_event_cnt), 32'd255);
    check("sat_cause", 32'(rst_cause), 32'd3);

    // Randomised episodes, checked cycle by cycle against the model.
    for (int ep = 0; ep < 60; ep++) begin
      len = $urandom_range(1, 2 * DEB);
      case ($urandom_range(0, 5))
        0: begin btn_fpga_rst_n = 1'b0; run(len); btn_fpga_rst_n = 1'b1; end
        1: begin btn_mcu_rst = 1'b1; run(len); btn_mcu_rst = 1'b0; end
        2: begin pll_locked = 1'b0; run($urandom_range(1, 6)); pll_locked = 1'b1; end
        3: begin
          btn_fpga_rst_n = 1'b0; btn_mcu_rst = 1'b1;
          run(len);
          btn_fpga_rst_n = 1'b1; btn_mcu_rst = 1'b0;
        end
        4: run($urandom_range(1, 150));
        default: if ($urandom_range(0, 3) == 0) async_pulse(1'b0); else run(len);
      endcase
      run($urandom_range(0, 120));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
